// File: rtl/clock_divider.sv
// -----------------------------------------------------------------------------
// clock_divider
//
// Purpose:
//   Clock-enable generator. It produces a registered single-cycle strobe,
//   `tick`, once every DIVISON cycles of `clk`. The GPU uses it to derive the
//   pixel-rate strobe from the fast system clock. `tick` is an ordinary
//   synchronous signal and is never used as a clock.
//
// Parameters:
//   DIVISON        - clock cycles per tick period, legal range 1..2**DIVISION_WIDTH
//   DIVISION_WIDTH - width of the internal cycle counter
//
// Ports:
//   clk   in   1  system clock; all state changes on the rising edge
//   rst   in   1  asynchronous, active-high reset (clears cnt and tick at once)
//   tick  out  1  registered pulse, high for one clk cycle per DIVISON cycles
// -----------------------------------------------------------------------------
module clock_divider #(
  parameter int DIVISON        = 4,
  parameter int DIVISION_WIDTH = 3
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  // Counter value at which the period ends and the strobe fires.
  localparam logic [DIVISION_WIDTH-1:0] TERMINAL = DIVISION_WIDTH'(DIVISON - 1);
  localparam logic [DIVISION_WIDTH-1:0] ONE      = DIVISION_WIDTH'(1);

  logic [DIVISION_WIDTH-1:0] cnt;

  // Reject parameter sets the counter cannot represent. A zero ratio has no
  // meaning, and a ratio beyond the counter range would never hit TERMINAL.
  generate
    if (DIVISON < 1 || DIVISON > (1 << DIVISION_WIDTH)) begin : g_bad_params
      $error("clock_divider: DIVISON=%0d is outside 1..2**DIVISION_WIDTH (DIVISION_WIDTH=%0d)",
             DIVISON, DIVISION_WIDTH);
    end
  endgenerate

  // Count 0..DIVISON-1 and wrap. The strobe is registered on the same edge as
  // the wrap, so it appears right after the DIVISON-th edge of each period.
  // The wrap is explicit, so cnt never goes past the terminal count. When
  // DIVISON equals 2**DIVISION_WIDTH, this wrap happens at the same point as
  // natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == TERMINAL) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + ONE;
      tick <= 1'b0;
    end
  end

endmodule

// File: tb/tb_clock_divider.sv
// -----------------------------------------------------------------------------
// tb_clock_divider
//
// Purpose:
//   Self-checking bench for clock_divider. Four instances share one clock and
//   have separate resets:
//     dut4 : DIVISON=4, DIVISION_WIDTH=3 (defaults)
//     dut1 : DIVISON=1, DIVISION_WIDTH=1
//     dut8 : DIVISON=8, DIVISION_WIDTH=3 (full counter range)
//     dut5 : DIVISON=5, DIVISION_WIDTH=3 (long run)
//   Each instance stays in reset until its own scenario runs. Inputs change on
//   or between edges. Outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_clock_divider;

  logic clk;
  logic rst4, rst1, rst8, rst5;
  logic tick4, tick1, tick8, tick5;

  int n_compared;
  int n_mismatched;

  clock_divider #(.DIVISON(4), .DIVISION_WIDTH(3)) dut4 (.clk(clk), .rst(rst4), .tick(tick4));
  clock_divider #(.DIVISON(1), .DIVISION_WIDTH(1)) dut1 (.clk(clk), .rst(rst1), .tick(tick1));
  clock_divider #(.DIVISON(8), .DIVISION_WIDTH(3)) dut8 (.clk(clk), .rst(rst8), .tick(tick8));
  clock_divider #(.DIVISON(5), .DIVISION_WIDTH(3)) dut5 (.clk(clk), .rst(rst5), .tick(tick5));

  // Free-running system clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run always ends even if a scenario stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset state: tick and cnt held at zero while rst is high.
  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      n_compared++;
      if (tick4 !== 1'b0) begin
        n_mismatched++;
        $display("[TB] FAIL reset_tick: got %b expected 0", tick4);
      end
      n_compared++;
      if (dut4.cnt !== 3'd0) begin
        n_mismatched++;
        $display("[TB] FAIL reset_cnt: got %0d expected 0", dut4.cnt);
      end
    end
  endtask

  // After release, tick fires on edges 4, 8, 12 and 16.
  task automatic test_default_period();
    logic exp;
    @(negedge clk);
    rst4 = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      step();
      exp = (k % 4 == 0);
      n_compared++;
      if (tick4 !== exp) begin
        n_mismatched++;
        $display("[TB] FAIL period_edge%0d: got %b expected %b", k, tick4, exp);
      end
    end
  endtask

  // Assert reset between edges while cnt=2. The clear takes effect without a
  // clock edge, and the period restarts from zero after release.
  task automatic test_async_reset_mid();
    logic exp;
    step();  // cnt 1
    step();  // cnt 2
    n_compared++;
    if (dut4.cnt !== 3'd2) begin
      n_mismatched++;
      $display("[TB] FAIL mid_pre_cnt: got %0d expected 2", dut4.cnt);
    end
    @(negedge clk);
    rst4 = 1'b1;
    #1;
    n_compared++;
    if (dut4.cnt !== 3'd0) begin
      n_mismatched++;
      $display("[TB] FAIL mid_async_cnt: got %0d expected 0", dut4.cnt);
    end
    n_compared++;
    if (tick4 !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL mid_async_tick: got %b expected 0", tick4);
    end
    step();
    n_compared++;
    if (dut4.cnt !== 3'd0 || tick4 !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL mid_hold: got cnt=%0d tick=%b expected cnt=0 tick=0", dut4.cnt, tick4);
    end
    @(negedge clk);
    rst4 = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      exp = (k == 4);
      n_compared++;
      if (tick4 !== exp) begin
        n_mismatched++;
        $display("[TB] FAIL mid_restart_edge%0d: got %b expected %b", k, tick4, exp);
      end
    end
  endtask

  // The previous scenario ends just after a tick edge. Resetting here must
  // drop tick at once.
  task automatic test_reset_during_tick();
    logic exp;
    n_compared++;
    if (tick4 !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL tickrst_pre: got %b expected 1", tick4);
    end
    #2;
    rst4 = 1'b1;
    #1;
    n_compared++;
    if (tick4 !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL tickrst_drop: got %b expected 0", tick4);
    end
    @(negedge clk);
    rst4 = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      exp = (k % 4 == 0);
      n_compared++;
      if (tick4 !== exp) begin
        n_mismatched++;
        $display("[TB] FAIL tickrst_after_edge%0d: got %b expected %b", k, tick4, exp);
      end
    end
  endtask

  // DIVISON=1: tick high on every cycle from the first edge, cnt stays 0.
  task automatic test_div1();
    n_compared++;
    if (tick1 !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL div1_reset: got %b expected 0", tick1);
    end
    @(negedge clk);
    rst1 = 1'b0;
    #1;
    n_compared++;
    if (tick1 !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL div1_pre_edge: got %b expected 0", tick1);
    end
    for (int k = 1; k <= 8; k++) begin
      step();
      n_compared++;
      if (tick1 !== 1'b1) begin
        n_mismatched++;
        $display("[TB] FAIL div1_edge%0d: got %b expected 1", k, tick1);
      end
      n_compared++;
      if (dut1.cnt !== 1'b0) begin
        n_mismatched++;
        $display("[TB] FAIL div1_cnt%0d: got %0d expected 0", k, dut1.cnt);
      end
    end
  endtask

  // Full-range counter: 40 cycles give 5 ticks, on edges 8, 16, 24, 32, 40.
  task automatic test_full_range();
    logic exp;
    int ticks;
    ticks = 0;
    @(negedge clk);
    rst8 = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      step();
      exp = (k % 8 == 0);
      if (tick8 === 1'b1) ticks++;
      n_compared++;
      if (tick8 !== exp) begin
        n_mismatched++;
        $display("[TB] FAIL full_edge%0d: got %b expected %b", k, tick8, exp);
      end
    end
    n_compared++;
    if (ticks !== 5) begin
      n_mismatched++;
      $display("[TB] FAIL full_count: got %0d expected 5", ticks);
    end
  endtask

  // Long run at DIVISON=5 over 100 cycles. The checker counts ticks, flags
  // any tick wider than one cycle, and flags any cnt value above 4.
  task automatic test_long_run();
    int ticks;
    int wide;
    int over;
    logic prev;
    ticks = 0;
    wide  = 0;
    over  = 0;
    prev  = 1'b0;
    @(negedge clk);
    rst5 = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      step();
      if (tick5 === 1'b1) ticks++;
      if (tick5 === 1'b1 && prev === 1'b1) wide++;
      if (dut5.cnt > 3'd4) over++;
      prev = tick5;
      n_compared++;
      if (tick5 !== (k % 5 == 0)) begin
        n_mismatched++;
        $display("[TB] FAIL long_edge%0d: got %b expected %b", k, tick5, (k % 5 == 0));
      end
    end
    n_compared++;
    if (ticks !== 20) begin
      n_mismatched++;
      $display("[TB] FAIL long_count: got %0d expected 20", ticks);
    end
    n_compared++;
    if (wide !== 0) begin
      n_mismatched++;
      $display("[TB] FAIL long_width: got %0d wide pulses expected 0", wide);
    end
    n_compared++;
    if (over !== 0) begin
      n_mismatched++;
      $display("[TB] FAIL long_cnt_range: got %0d out-of-range samples expected 0", over);
    end
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    rst4 = 1'b1;
    rst1 = 1'b1;
    rst8 = 1'b1;
    rst5 = 1'b1;

    test_reset();
    test_default_period();
    test_async_reset_mid();
    test_reset_during_tick();
    test_div1();
    test_full_range();
    test_long_run();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
